bf_addsub: RTL and testbench

Post-multiplier stage of the NTT butterfly. It consumes the `t = w·b` product from `mo_mul`. It aligns that product with the `a` operand, which was captured when the multiplier operands were issued. It produces the Cooley-Tukey outputs `a+t mod Q` and `a−t mod Q`, fully reduced to `[0,Q)`. It also counts completed butterflies and pulses a stage-done flag, so the NTT controller can advance to the next stage.

---
 rtl/bf_addsub.sv | 132 +++++++++++++
 tb/tb_bf_addsub.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bf_addsub.sv
// ----------------------------------------------------------------------------
// bf_addsub : NTT butterfly add/sub stage, (a+t) mod Q and (a-t) mod Q.
// Optional macro BF_DIV2_EN adds an R3 stage that halves both outputs mod Q.
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bf_addsub #(
  parameter int DATA_WIDTH    = 12,
  parameter int Q             = 3329,
  parameter int MUL_STAGE_CNT = 3,
  parameter int BF_CNT        = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] t,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_even,
  output logic [DATA_WIDTH-1:0] out_odd,
  output logic                  stage_done
);

  localparam int             W1      = DATA_WIDTH + 1;
  localparam logic [W1-1:0]  C_Q     = W1'(Q);
  localparam int             CW      = $clog2(BF_CNT + 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(BF_CNT - 1);

  logic [DATA_WIDTH-1:0]    a_dl_q [MUL_STAGE_CNT];
  logic [DATA_WIDTH-1:0]    a_dl_d [MUL_STAGE_CNT];
  logic [MUL_STAGE_CNT-1:0] v_dl_q, v_dl_d;

  logic [W1-1:0]         sum_q, sum_d, diff_q, diff_d;
  logic                  v1_q, v1_d;
  logic [DATA_WIDTH-1:0] r2_even_q, r2_even_d, r2_odd_q, r2_odd_d;
  logic                  v2_q, v2_d;
  logic [CW-1:0]         bf_cnt_q, bf_cnt_d;
  logic                  fin_valid;

  always_comb begin
    a_dl_d[0] = a;
    v_dl_d[0] = in_valid;
    for (int i = 1; i < MUL_STAGE_CNT; i++) begin
      a_dl_d[i] = a_dl_q[i-1];
      v_dl_d[i] = v_dl_q[i-1];
    end
    // diff is biased by Q so it never goes negative for t < Q
    sum_d     = {1'b0, a_dl_q[MUL_STAGE_CNT-1]} + {1'b0, t};
    diff_d    = {1'b0, a_dl_q[MUL_STAGE_CNT-1]} + C_Q - {1'b0, t};
    v1_d      = v_dl_q[MUL_STAGE_CNT-1];
    r2_even_d = DATA_WIDTH'((sum_q  >= C_Q) ? sum_q  - C_Q : sum_q);
    r2_odd_d  = DATA_WIDTH'((diff_q >= C_Q) ? diff_q - C_Q : diff_q);
    v2_d      = v1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGE_CNT; i++) a_dl_q[i] <= '0;
      v_dl_q    <= '0;
      sum_q     <= '0;
      diff_q    <= '0;
      v1_q      <= 1'b0;
      r2_even_q <= '0;
      r2_odd_q  <= '0;
      v2_q      <= 1'b0;
    end else begin
      a_dl_q    <= a_dl_d;
      v_dl_q    <= v_dl_d;
      sum_q     <= sum_d;
      diff_q    <= diff_d;
      v1_q      <= v1_d;
      r2_even_q <= r2_even_d;
      r2_odd_q  <= r2_odd_d;
      v2_q      <= v2_d;
    end
  end

`ifdef BF_DIV2_EN
  logic [DATA_WIDTH-1:0] r3_even_q, r3_even_d, r3_odd_q, r3_odd_d;
  logic                  v3_q, v3_d;

  // Multiply by 2^-1 mod Q: odd values are made even by adding Q first
  function automatic logic [DATA_WIDTH-1:0] half_mod(input logic [DATA_WIDTH-1:0] x);
    logic [W1-1:0] s;
    s = x[0] ? ({1'b0, x} + C_Q) : {1'b0, x};
    return DATA_WIDTH'(s >> 1);
  endfunction

  always_comb begin
    r3_even_d = half_mod(r2_even_q);
    r3_odd_d  = half_mod(r2_odd_q);
    v3_d      = v2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_even_q <= '0;
      r3_odd_q  <= '0;
      v3_q      <= 1'b0;
    end else begin
      r3_even_q <= r3_even_d;
      r3_odd_q  <= r3_odd_d;
      v3_q      <= v3_d;
    end
  end

  assign fin_valid = v3_q;
  assign out_even  = r3_even_q;
  assign out_odd   = r3_odd_q;
`else
  assign fin_valid = v2_q;
  assign out_even  = r2_even_q;
  assign out_odd   = r2_odd_q;
`endif

  always_comb begin
    bf_cnt_d = bf_cnt_q;
    if (fin_valid) bf_cnt_d = (bf_cnt_q == C_LAST) ? '0 : bf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) bf_cnt_q <= '0;
    else     bf_cnt_q <= bf_cnt_d;
  end

  assign out_valid  = fin_valid;
  assign stage_done = fin_valid && (bf_cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: tb/tb_bf_addsub.sv
// ----------------------------------------------------------------------------
// tb_bf_addsub : scoreboard bench for bf_addsub with a modular-arithmetic model.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bf_addsub;

  localparam int DW  = 12;
  localparam int Q   = 3329;
  localparam int M   = 3;
  localparam int BFC = 4;
`ifdef BF_DIV2_EN
  localparam int LAT = M + 3;
`else
  localparam int LAT = M + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] t = '0;
  logic          out_valid, stage_done;
  logic [DW-1:0] out_even, out_odd;

  bf_addsub #(.DATA_WIDTH(DW), .Q(Q), .MUL_STAGE_CNT(M), .BF_CNT(BFC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .t(t),
    .out_valid(out_valid), .out_even(out_even), .out_odd(out_odd),
    .stage_done(stage_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ev;
    int od;
    bit sd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_stage = 0;
  int   t_slot[8];

  function automatic int scale(input int x);
`ifdef BF_DIV2_EN
    return (x * ((Q + 1) / 2)) % Q;
`else
    return x;
`endif
  endfunction

  // One clock cycle of stimulus; t for a butterfly is delivered M cycles later
  task automatic step(input bit v, input int av, input int tv, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    a        = DW'(av);
    t        = DW'(t_slot[cyc % 8]);
    if (v) t_slot[(cyc + M) % 8] = tv;
    if (r) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      n_stage = 0;
    end else if (v) begin
      e.cyc = cyc + LAT;
      e.ev  = scale((av + tv) % Q);
      e.od  = scale((av + Q - tv) % Q);
      e.sd  = (n_stage == BFC - 1);
      sb.push_back(e);
      n_stage = (n_stage + 1) % BFC;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic rnd_bf();
    step(1'b1, int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)), 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: every cycle either an expected result is due or the outputs are idle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (!out_valid || out_even != DW'(e.ev) || out_odd != DW'(e.od) || stage_done != e.sd) begin
          n_err++;
          $display("FAIL bf cyc=%0d: got v=%0b even=%0d odd=%0d sd=%0b, required v=1 even=%0d odd=%0d sd=%0b",
                   cyc, out_valid, out_even, out_odd, stage_done, e.ev, e.od, e.sd);
        end
      end else if (out_valid || stage_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL idle cyc=%0d: got v=%0b sd=%0b, required v=0 sd=0", cyc, out_valid, stage_done);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) t_slot[i] = 0;
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 100, 200, 1'b1);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_stage_done", int'(stage_done), 0);
    chk("rst_out_even", int'(out_even), 0);
    chk("rst_out_odd", int'(out_odd), 0);

    // Basic and boundary butterflies; the 4th closes a stage
    step(1'b1, 3000, 1000, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 5, 3328, 1'b0);
    step(1'b1, 3328, 3328, 1'b0);
    idle(8);

    // 8 back-to-back butterflies
    for (int i = 0; i < 8; i++) rnd_bf();
    idle(3);

    // Gap pattern 1,0,1,1
    rnd_bf();
    idle(1);
    rnd_bf();
    rnd_bf();
    idle(8);

    // Reset with 3 in flight plus a same-cycle in_valid, then a fresh stage
    rnd_bf();
    rnd_bf();
    rnd_bf();
    step(1'b1, 1234, 2345, 1'b1);
    idle(8);
    for (int i = 0; i < 5; i++) rnd_bf();
    idle(2);

    // Random sweep with random gaps
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) != 0) rnd_bf();
      else idle(1);
    end
    idle(LAT + 4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
